ram_weights_ctrl: RTL and testbench
===================================

RAM_WEIGHTS_CTRL -- requirements
Module: ram_weights_ctrl

Interface
REQ-001 Parameter DEPTH, default `RAM_WEIGHTS_DEPTH: word count of the controlled single-port RAM.
REQ-002 Parameter WIDTH, default `K_BITS: RAM data width.
REQ-003 Parameter LATENCY, default `DELAY_W_RAM: total RAM read latency in cycles, >=1.
REQ-004 Parameter ADDR_WIDTH, default $clog2(DEPTH): address width.
REQ-005 clk  in  1  sole clock; all logic on rising edge.
REQ-006 rst  in  1  reset; synchronous, active-high.
REQ-007 s_data  in  WIDTH  fill word; s_valid in 1; s_ready out 1; s_last in 1 marks final fill word.
REQ-008 rd_valid  in  1  read request; rd_addr in ADDR_WIDTH; rd_ready out 1 request accepted.
REQ-009 release  in  1  single-cycle pulse: consumer finished, buffer may be refilled.
REQ-010 m_data  out  WIDTH  read data; m_valid out 1 qualifies m_data.
REQ-011 ram_en, ram_we  out 1 each; ram_addr out ADDR_WIDTH; ram_di out WIDTH; ram_dout in WIDTH: RAM port.
REQ-012 loaded  out  1  high in READ state; word_count out ADDR_WIDTH+1  words written by last fill.

Function
REQ-013 FSM states FILL, READ, DRAIN; one-hot or binary, implementer's choice.
REQ-014 ram_en SHALL be constant 1 so the RAM output delay line always advances.
REQ-015 FILL: s_ready=1, rd_ready=0; on s_valid: ram_we=1, ram_addr=wr_ptr, ram_di=s_data, wr_ptr+1.
REQ-016 FILL -> READ after the beat with s_valid&s_last, or the beat written at wr_ptr=DEPTH-1 (whichever first); word_count latches wr_ptr+1 that cycle.
REQ-017 READ: s_ready=0, rd_ready=1, ram_we=0; rd_valid&rd_ready drives ram_addr=rd_addr, one request per cycle, no bubbles.
REQ-018 m_valid SHALL assert exactly LATENCY cycles after an accepted request, with m_data=ram_dout, via a LATENCY-deep valid shift register.
REQ-019 release in READ -> DRAIN; a request in the same cycle as release SHALL be accepted and returned.
REQ-020 DRAIN: s_ready=0, rd_ready=0; -> FILL with wr_ptr=0 the cycle after the valid shift register is all-zero.
REQ-021 release outside READ SHALL be ignored; s_last with s_valid=0 SHALL be ignored.
REQ-022 Outside accepted writes/reads, ram_we=0 and ram_addr holds its last value.

Reset
REQ-023 rst SHALL force state=FILL, wr_ptr=0, word_count=0, valid shift register cleared, m_valid=0, ram_we=0, ram_addr=0, s_ready=1 after the reset edge.
REQ-024 rst mid-read SHALL discard all in-flight reads: no m_valid pulse after reset deasserts for pre-reset requests.

Configuration
REQ-025 Macro RAM_WEIGHTS_CTRL_BOUNDS_EN defined: in READ, rd_ready=0 when rd_addr>=word_count, and sticky output bounds_err (1 bit, reset 0, cleared only by rst) sets on any rd_valid with out-of-range address.
REQ-026 Macro undefined: no bounds check, bounds_err port absent, any rd_addr accepted in READ.

Verification
REQ-027 Fill 4 words 0xA..0xD, s_last on 4th -> RAM writes addr 0..3, loaded=1 next cycle, word_count=4.
REQ-028 READ, back-to-back rd_addr 3,0,2 with LATENCY=2 -> m_valid on cycles t+2..t+4, m_data 0xD,0xA,0xC.
REQ-029 Fill DEPTH words with no s_last -> auto-transition to READ after word DEPTH-1, word_count=DEPTH.
REQ-030 release same cycle as a read request, LATENCY=3 -> that data returns, FILL entered only after last m_valid, s_ready=1.
REQ-031 rst asserted 1 cycle after a read request -> m_valid stays 0, state FILL, wr_ptr=0.
REQ-032 With BOUNDS_EN, word_count=4, rd_addr=5 -> rd_ready=0, no m_valid, bounds_err=1 and holds.

Source files
------------

// File: rtl/ram_weights_ctrl_if.sv
// Bundle of fill, read, release, result and RAM-port signals for ram_weights_ctrl.
// bounds_err exists only when RAM_WEIGHTS_CTRL_BOUNDS_EN is defined.
interface ram_weights_ctrl_if #(
   parameter int WIDTH      = 8,
   parameter int ADDR_WIDTH = 4
);
   logic [WIDTH-1:0]      s_data;
   logic                  s_valid;
   logic                  s_ready;
   logic                  s_last;

   logic                  rd_valid;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic                  rd_ready;

   // "release" is a language keyword, hence the prefix
   logic                  buf_release;

   logic [WIDTH-1:0]      m_data;
   logic                  m_valid;

   logic                  ram_en;
   logic                  ram_we;
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic [WIDTH-1:0]      ram_di;
   logic [WIDTH-1:0]      ram_dout;

   logic                  loaded;
   logic [ADDR_WIDTH:0]   word_count;
`ifdef RAM_WEIGHTS_CTRL_BOUNDS_EN
   logic                  bounds_err;
`endif

   modport slave (
`ifdef RAM_WEIGHTS_CTRL_BOUNDS_EN
      output bounds_err,
`endif
      input  s_data, s_valid, s_last,
      output s_ready,
      input  rd_valid, rd_addr,
      output rd_ready,
      input  buf_release,
      output m_data, m_valid,
      output ram_en, ram_we, ram_addr, ram_di,
      input  ram_dout,
      output loaded, word_count
   );

   modport master (
`ifdef RAM_WEIGHTS_CTRL_BOUNDS_EN
      input  bounds_err,
`endif
      output s_data, s_valid, s_last,
      input  s_ready,
      output rd_valid, rd_addr,
      input  rd_ready,
      output buf_release,
      input  m_data, m_valid,
      input  ram_en, ram_we, ram_addr, ram_di,
      output ram_dout,
      input  loaded, word_count
   );
endinterface

// File: rtl/ram_weights_ctrl.sv
// Fill/read/drain controller for a single-port weight RAM with fixed read latency.
// Optional read address bounds check: define RAM_WEIGHTS_CTRL_BOUNDS_EN.
`ifndef RAM_WEIGHTS_DEPTH
`define RAM_WEIGHTS_DEPTH 256
`endif
`ifndef K_BITS
`define K_BITS 8
`endif
`ifndef DELAY_W_RAM
`define DELAY_W_RAM 2
`endif

module ram_weights_ctrl #(
   parameter int DEPTH      = `RAM_WEIGHTS_DEPTH,
   parameter int WIDTH      = `K_BITS,
   parameter int LATENCY    = `DELAY_W_RAM,
   parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
   input logic               clk,
   input logic               rst,
   ram_weights_ctrl_if.slave bus
);
   typedef enum logic [1:0] {ST_FILL, ST_READ, ST_DRAIN} state_t;

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
   localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH:0]   WC_ONE    = (ADDR_WIDTH + 1)'(1);

   state_t                r_state, w_state_next;
   logic [ADDR_WIDTH-1:0] r_wr_ptr, w_wr_ptr_next;
   logic [ADDR_WIDTH-1:0] r_ram_addr, w_ram_addr_next;
   logic [ADDR_WIDTH:0]   r_word_count, w_word_count_next;
   logic [LATENCY-1:0]    r_vld_sr, w_vld_sr_next;
   logic                  w_s_ready, w_rd_ready, w_ram_we;
   logic                  w_rd_accept, w_addr_ok;

`ifdef RAM_WEIGHTS_CTRL_BOUNDS_EN
   logic r_bounds_err, w_bounds_err_next;
   assign w_addr_ok = ({1'b0, bus.rd_addr} < r_word_count);
   assign w_bounds_err_next = r_bounds_err
                            | ((r_state == ST_READ) & bus.rd_valid & ~w_addr_ok);
   assign bus.bounds_err = r_bounds_err;
`else
   assign w_addr_ok = 1'b1;
`endif

   // One bit per pipeline stage of the RAM; the oldest bit qualifies ram_dout.
   generate
      for (genvar gi = 0; gi < LATENCY; gi++) begin : g_vld
         if (gi == 0) begin : g_head
            assign w_vld_sr_next[gi] = w_rd_accept;
         end else begin : g_tail
            assign w_vld_sr_next[gi] = r_vld_sr[gi-1];
         end
      end
   endgenerate

   always_comb begin
      w_state_next      = r_state;
      w_wr_ptr_next     = r_wr_ptr;
      w_word_count_next = r_word_count;
      w_ram_addr_next   = r_ram_addr;
      w_s_ready         = 1'b0;
      w_rd_ready        = 1'b0;
      w_ram_we          = 1'b0;
      w_rd_accept       = 1'b0;
      case (r_state)
         ST_FILL: begin
            w_s_ready = 1'b1;
            if (bus.s_valid) begin
               w_ram_we        = 1'b1;
               w_ram_addr_next = r_wr_ptr;
               w_wr_ptr_next   = r_wr_ptr + PTR_ONE;
               if (bus.s_last || (r_wr_ptr == LAST_ADDR)) begin
                  w_state_next      = ST_READ;
                  w_word_count_next = {1'b0, r_wr_ptr} + WC_ONE;
               end
            end
         end
         ST_READ: begin
            w_rd_ready  = w_addr_ok;
            w_rd_accept = bus.rd_valid & w_addr_ok;
            if (w_rd_accept) begin
               w_ram_addr_next = bus.rd_addr;
            end
            if (bus.buf_release) begin
               w_state_next = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            // Leave only once every issued read has come back out
            if (r_vld_sr == '0) begin
               w_state_next  = ST_FILL;
               w_wr_ptr_next = '0;
            end
         end
         default: begin
            w_state_next = ST_FILL;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_FILL;
         r_wr_ptr     <= '0;
         r_word_count <= '0;
         r_vld_sr     <= '0;
         r_ram_addr   <= '0;
`ifdef RAM_WEIGHTS_CTRL_BOUNDS_EN
         r_bounds_err <= 1'b0;
`endif
      end else begin
         r_state      <= w_state_next;
         r_wr_ptr     <= w_wr_ptr_next;
         r_word_count <= w_word_count_next;
         r_vld_sr     <= w_vld_sr_next;
         r_ram_addr   <= w_ram_addr_next;
`ifdef RAM_WEIGHTS_CTRL_BOUNDS_EN
         r_bounds_err <= w_bounds_err_next;
`endif
      end
   end

   assign bus.s_ready    = w_s_ready;
   assign bus.rd_ready   = w_rd_ready;
   assign bus.ram_en     = 1'b1;
   assign bus.ram_we     = w_ram_we;
   assign bus.ram_addr   = w_ram_addr_next;
   assign bus.ram_di     = bus.s_data;
   assign bus.m_valid    = r_vld_sr[LATENCY-1];
   assign bus.m_data     = bus.ram_dout;
   assign bus.loaded     = (r_state == ST_READ);
   assign bus.word_count = r_word_count;
endmodule

// File: tb/tb_ram_weights_ctrl.sv
// Bench for ram_weights_ctrl: RAM model with LATENCY-deep read pipe, a phase-level
// reference model checked every cycle, and directed scenarios with literal expectations.
module tb_ram_weights_ctrl;
   localparam int DEPTH = 8;
   localparam int WIDTH = 8;
   localparam int LAT   = 3;
   localparam int AW    = $clog2(DEPTH);
   localparam int NS    = 4096;
   localparam int P_FILL  = 0;
   localparam int P_READ  = 1;
   localparam int P_DRAIN = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ram_weights_ctrl_if #(.WIDTH(WIDTH), .ADDR_WIDTH(AW)) bus ();

   ram_weights_ctrl #(
      .DEPTH(DEPTH), .WIDTH(WIDTH), .LATENCY(LAT), .ADDR_WIDTH(AW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   // RAM: data for the address presented in cycle c appears on ram_dout in cycle c+LAT
   logic [WIDTH-1:0] ram_mem  [DEPTH];
   logic [WIDTH-1:0] ram_pipe [LAT];
   always @(posedge clk) begin
      if (bus.ram_en) begin
         if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_di;
         ram_pipe[0] <= ram_mem[bus.ram_addr];
         for (int i = 1; i < LAT; i++) ram_pipe[i] <= ram_pipe[i-1];
      end
   end
   assign bus.ram_dout = ram_pipe[LAT-1];

   int n_tests = 0;
   int n_fail  = 0;
   bit started = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference model: buffer phase, fill pointer, word count, expected returns per cycle
   int cyc      = 0;
   int ph       = P_FILL;
   int m_wr     = 0;
   int m_wc     = 0;
   int m_hold   = 0;
   int last_ret = -100;
   logic [WIDTH-1:0] exp_mem [DEPTH];
   bit               sv [NS];
   logic [WIDTH-1:0] sd [NS];

   function automatic bit addr_ok(input int a);
`ifdef RAM_WEIGHTS_CTRL_BOUNDS_EN
      return a < m_wc;
`else
      return (a >= 0);
`endif
   endfunction

   function automatic int exp_addr();
      if (ph == P_FILL && bus.s_valid) return m_wr;
      if (ph == P_READ && bus.rd_valid && addr_ok(int'(bus.rd_addr))) return int'(bus.rd_addr);
      return m_hold;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         ph       <= P_FILL;
         m_wr     <= 0;
         m_wc     <= 0;
         m_hold   <= 0;
         last_ret <= -100;
         for (int i = 1; i <= LAT; i++) sv[(cyc + i) % NS] <= 1'b0;
      end else begin
         case (ph)
            P_FILL: if (bus.s_valid) begin
               exp_mem[m_wr] <= bus.s_data;
               m_hold        <= m_wr;
               m_wr          <= m_wr + 1;
               if (bus.s_last || m_wr == DEPTH - 1) begin
                  ph   <= P_READ;
                  m_wc <= m_wr + 1;
               end
            end
            P_READ: begin
               if (bus.rd_valid && addr_ok(int'(bus.rd_addr))) begin
                  sv[(cyc + LAT) % NS] <= 1'b1;
                  sd[(cyc + LAT) % NS] <= exp_mem[bus.rd_addr];
                  m_hold   <= int'(bus.rd_addr);
                  last_ret <= cyc + LAT;
               end
               if (bus.buf_release) ph <= P_DRAIN;
            end
            default: if (cyc >= last_ret + 1) begin
               ph   <= P_FILL;
               m_wr <= 0;
            end
         endcase
      end
      cyc <= cyc + 1;
   end

   always @(negedge clk) begin
      if (started && !rst) begin
         chk("ram_en", 32'(bus.ram_en), 32'(1));
         chk("s_ready", 32'(bus.s_ready), 32'(ph == P_FILL));
         chk("rd_ready", 32'(bus.rd_ready),
             32'(ph == P_READ && addr_ok(int'(bus.rd_addr))));
         chk("loaded", 32'(bus.loaded), 32'(ph == P_READ));
         chk("word_count", 32'(bus.word_count), m_wc);
         chk("ram_we", 32'(bus.ram_we), 32'(ph == P_FILL && bus.s_valid));
         chk("ram_addr", 32'(bus.ram_addr), exp_addr());
         if (ph == P_FILL && bus.s_valid) chk("ram_di", 32'(bus.ram_di), 32'(bus.s_data));
         chk("m_valid", 32'(bus.m_valid), 32'(sv[cyc % NS]));
         if (sv[cyc % NS]) chk("m_data", 32'(bus.m_data), 32'(sd[cyc % NS]));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_cyc(input int target);
      int n = 0;
      while (cyc < target && n < 50) begin
         tick();
         n++;
      end
      chk("wait_cyc", cyc, target);
   endtask

   task automatic fill(input int n, input logic [WIDTH-1:0] base, input bit use_last);
      for (int i = 0; i < n; i++) begin
         bus.s_valid = 1'b1;
         bus.s_data  = base + WIDTH'(i);
         bus.s_last  = use_last && (i == n - 1);
         tick();
      end
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

   int t0;
   initial begin
      bus.s_data = '0; bus.s_valid = 1'b0; bus.s_last = 1'b0;
      bus.rd_valid = 1'b0; bus.rd_addr = '0; bus.buf_release = 1'b0;
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      started = 1'b1;

      chk("rst_s_ready", 32'(bus.s_ready), 32'(1));
      chk("rst_rd_ready", 32'(bus.rd_ready), 32'(0));
      chk("rst_loaded", 32'(bus.loaded), 32'(0));
      chk("rst_m_valid", 32'(bus.m_valid), 32'(0));
      chk("rst_ram_we", 32'(bus.ram_we), 32'(0));
      chk("rst_ram_addr", 32'(bus.ram_addr), 32'(0));
      chk("rst_word_count", 32'(bus.word_count), 32'(0));
`ifdef RAM_WEIGHTS_CTRL_BOUNDS_EN
      chk("rst_bounds_err", 32'(bus.bounds_err), 32'(0));
`endif

      // release and a bare s_last during FILL change nothing
      bus.buf_release = 1'b1; tick(); bus.buf_release = 1'b0;
      bus.s_last = 1'b1; tick(); bus.s_last = 1'b0;
      chk("ignore_s_ready", 32'(bus.s_ready), 32'(1));
      chk("ignore_loaded", 32'(bus.loaded), 32'(0));

      // fill 0xA..0xD, s_last on the fourth
      fill(4, 8'h0A, 1'b1);
      chk("fill4_loaded", 32'(bus.loaded), 32'(1));
      chk("fill4_word_count", 32'(bus.word_count), 32'(4));
      for (int i = 0; i < 4; i++) chk("fill4_ram", 32'(ram_mem[i]), 32'h0A + i);

      // back-to-back reads 3,0,2
      t0 = cyc;
      bus.rd_valid = 1'b1;
      bus.rd_addr = 3'd3; tick();
      bus.rd_addr = 3'd0; tick();
      bus.rd_addr = 3'd2; tick();
      bus.rd_valid = 1'b0;
      wait_cyc(t0 + LAT);
      chk("rd0_valid", 32'(bus.m_valid), 32'(1));
      chk("rd0_data", 32'(bus.m_data), 32'h0D);
      tick();
      chk("rd1_data", 32'(bus.m_data), 32'h0A);
      tick();
      chk("rd2_data", 32'(bus.m_data), 32'h0C);
      tick();
      chk("rd_end_valid", 32'(bus.m_valid), 32'(0));

      // release together with a read; a request during DRAIN is refused
      t0 = cyc;
      bus.rd_valid = 1'b1; bus.rd_addr = 3'd1; bus.buf_release = 1'b1;
      tick();
      bus.buf_release = 1'b0; bus.rd_addr = 3'd2;
      chk("drain_rd_ready", 32'(bus.rd_ready), 32'(0));
      chk("drain_s_ready", 32'(bus.s_ready), 32'(0));
      tick();
      bus.rd_valid = 1'b0;
      wait_cyc(t0 + LAT);
      chk("rel_valid", 32'(bus.m_valid), 32'(1));
      chk("rel_data", 32'(bus.m_data), 32'h0B);
      chk("rel_s_ready_a", 32'(bus.s_ready), 32'(0));
      tick();
      chk("rel_s_ready_b", 32'(bus.s_ready), 32'(0));
      tick();
      chk("rel_s_ready_c", 32'(bus.s_ready), 32'(1));

      // full-depth fill without s_last
      fill(DEPTH, 8'h10, 1'b0);
      chk("full_loaded", 32'(bus.loaded), 32'(1));
      chk("full_word_count", 32'(bus.word_count), 32'(DEPTH));
      chk("full_ram7", 32'(ram_mem[DEPTH-1]), 32'h17);
      bus.s_valid = 1'b1; bus.s_data = 8'hFF; tick(); bus.s_valid = 1'b0;
      t0 = cyc;
      bus.rd_valid = 1'b1; bus.rd_addr = 3'd7; tick(); bus.rd_valid = 1'b0;
      wait_cyc(t0 + LAT);
      chk("full_rd7_data", 32'(bus.m_data), 32'h17);

      // reset one cycle after a read request discards it
      bus.rd_valid = 1'b1; bus.rd_addr = 3'd5; tick(); bus.rd_valid = 1'b0;
      rst = 1'b1; tick(); rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         chk("rstrd_m_valid", 32'(bus.m_valid), 32'(0));
         tick();
      end
      chk("rstrd_s_ready", 32'(bus.s_ready), 32'(1));
      chk("rstrd_word_count", 32'(bus.word_count), 32'(0));

      fill(4, 8'h55, 1'b1);
      chk("refill_ram0", 32'(ram_mem[0]), 32'h55);
      chk("refill_ram3", 32'(ram_mem[3]), 32'h58);
      chk("refill_word_count", 32'(bus.word_count), 32'(4));

`ifdef RAM_WEIGHTS_CTRL_BOUNDS_EN
      bus.rd_valid = 1'b1; bus.rd_addr = 3'd5;
      chk("oob_rd_ready", 32'(bus.rd_ready), 32'(0));
      tick();
      bus.rd_valid = 1'b0;
      chk("oob_bounds_err", 32'(bus.bounds_err), 32'(1));
      repeat (4) tick();
      chk("oob_bounds_hold", 32'(bus.bounds_err), 32'(1));
`endif

      repeat (2) tick();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
